mux_rr_arbiter: RTL
===================

# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 select mux among four requesters. It owns the mux select lines, issuing sel_out[1] to the mux b_in and sel_out[0] to its c_in. It issues a registered one-hot grant and holds it for a requester's burst. An optional hold-time limit forces rotation under contention.

## Interface
Parameters:
- MAX_HOLD, 8: maximum consecutive granted cycles per requester when contention exists (only with timeout feature); legal range 2..256.

Ports:
- clk_in  input  1  single clock; all state updates on rising edge.
- rst_in  input  1  reset; synchronous, active-high.
- req_in  input  4  request per mux input; req_in[k] asks for mux input i<k>_in.
- grant_out  output  4  one-hot grant, or all-zero when idle; registered.
- sel_out  output  2  mux select index; bit 1 → mux b_in, bit 0 → mux c_in; registered.
- sel_valid_out  output  1  high when grant_out is nonzero, i.e. y_out reflects a granted input.
- busy_out  output  1  high in GRANT state; identical to sel_valid_out, kept for downstream flow control.

## Operation
- States:
  - IDLE: no grant.
  - GRANT: grant_out = one-hot(cur), sel_out = cur.
- Priority pointer ptr (2 bits) holds the index searched first. After each grant to k, ptr = k+1 mod 4 (3 wraps to 0).
- IDLE:
  - Any req_in bit set → pick first set bit scanning ptr, ptr+1, … mod 4. Load cur, go to GRANT, clear the hold counter.
  - Otherwise stay in IDLE.
- GRANT, release condition is req_in[cur]==0:
  - Scan the other requesters from cur+1 mod 4.
  - If one is found, hand off directly: GRANT→GRANT with the new cur and the counter cleared. No idle gap.
  - If none is found, go to IDLE with grant_out=0.
- GRANT, req_in[cur] still high: keep the grant and increment the hold counter (timeout behaviour per Configuration).
- sel_out holds the last granted index in IDLE. It is never driven to an ungranted value while sel_valid_out=1.
- Simultaneous release and new requests: new requests are considered in the same edge; the release path above applies.
- Requests that appear while another requester is granted are not served until release/rotation. No request is ever lost while it stays asserted. Worst-case wait: 3 × burst (timeout enabled: 3 × MAX_HOLD cycles).
- Reset mid-burst: next edge forces IDLE, grant dropped immediately, ptr=0, counter cleared.

## Timing
- Reset values: grant_out=4'b0000, sel_out=2'b00, sel_valid_out=0, busy_out=0, ptr=0, state IDLE.
- Grant latency is 1 cycle. A req_in sampled at edge N gives grant_out/sel_out valid after edge N.
- Release latency is 1 cycle. req_in[cur] low at edge N gives a new grant or idle after edge N.
- All outputs change only on clk_in rising edges. No combinational path from req_in to any output.
- The hold counter is $clog2(MAX_HOLD) bits wide. It counts granted cycles from 0 and never overflows.

## Configuration
- MUX_ARB_TIMEOUT_EN defined:
  - When the hold counter reaches MAX_HOLD-1 while req_in[cur]=1 and another requester is asserted, rotate at the next edge as if released. cur keeps its request and rejoins round-robin.
  - If no other requester is asserted at expiry, keep the grant and clear the counter.
- MUX_ARB_TIMEOUT_EN undefined:
  - No hold counter logic; MAX_HOLD is ignored.
  - The grant is held until req_in[cur] drops.

## Structure
- Package mux_arb_pkg:
  - constants NUM_REQ=4, SEL_W=2;
  - state enum {IDLE, GRANT};
  - function onehot(sel) returning the 4-bit grant.
- One sub-module, rr_pick: combinational. Inputs are the 4-bit request mask and a 2-bit start index; outputs are found and idx (first set bit at or after start, mod 4). It is instantiated once and serves both IDLE and handoff searches (mask excludes cur for handoff).

## Test plan
- Reset then req_in=4'b0100 → one cycle later grant_out=4'b0100, sel_out=2'b10, sel_valid_out=1; ptr becomes 3.
- req_in=4'b1111 held, each requester dropping its request after 3 granted cycles → grants rotate 0,1,2,3,0 with direct handoff, no idle cycle, sel_out 00,01,10,11,00.
- Single requester drops its request with no others pending → next cycle grant_out=0, sel_valid_out=0, sel_out holds last index.
- With MUX_ARB_TIMEOUT_EN and MAX_HOLD=4:
  - req_in=4'b0011 held → grant 0 for exactly 4 cycles, then 1 for 4, alternating.
  - req_in=4'b0001 alone → grant 0 held indefinitely.
- Without the macro, req_in=4'b0011 held 20 cycles → grant stays 4'b0001 throughout.
- Assert rst_in for 1 cycle mid-burst with req_in=4'b1010 → after that edge all outputs at reset values. The following edge grants requester 1 (ptr=0 scan).

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux-select arbiter.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Circular first-set-bit search: first mask bit at or after start, wrapping mod NUM_REQ.
module rr_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] mask,
  input  logic [SEL_W-1:0]   start,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    found = 1'b0;
    idx   = start;
    cand  = start;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = start + SEL_W'(i);
      if (mask[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the 4:1 mux select; registered one-hot grant held per burst.
// Optional hold-time limit under contention: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out,
  output logic [SEL_W-1:0]   sel_out,
  output logic               sel_valid_out,
  output logic               busy_out
);

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("MAX_HOLD must lie in 2..256");
  end

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] pick_mask;
  logic [SEL_W-1:0]   pick_start;
  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               rotate;
  logic               load;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expire;
  logic             others;

  assign others = |(req_in & ~onehot(cur_q));
  assign expire = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rotate = !req_in[cur_q] || (expire && others);
`else
  assign rotate = !req_in[cur_q];
`endif

  // Handoff search excludes the current owner and starts just past it.
  always_comb begin
    pick_mask  = req_in;
    pick_start = ptr_q;
    if (state_q == GRANT) begin
      pick_mask  = req_in & ~onehot(cur_q);
      pick_start = cur_q + 2'd1;
    end
  end

  rr_pick u_pick (
    .mask  (pick_mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    ptr_d   = ptr_q;
    load    = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    if (state_q == IDLE) begin
      load = pick_found;
    end else if (rotate) begin
      if (pick_found) load = 1'b1;
      else            state_d = IDLE;
    end else begin
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_d = expire ? '0 : cnt_q + 1'b1;
`endif
    end
    if (load) begin
      state_d = GRANT;
      cur_d   = pick_idx;
      ptr_d   = pick_idx + 2'd1;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end
    grant_d = (state_d == GRANT) ? onehot(cur_d) : '0;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      cur_q   <= '0;
      ptr_q   <= '0;
      grant_q <= '0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign grant_out     = grant_q;
  assign sel_out       = cur_q;
  assign sel_valid_out = (state_q == GRANT);
  assign busy_out      = (state_q == GRANT);

endmodule
